// File: rtl/add_accumulator.sv
// rtl/add_accumulator.sv - accumulates 4-bit operand/carry-in beats into a wider burst total
//
// Purpose:
//   Consumes beats of (in_data + in_cin) over a valid/ready handshake and sums
//   them into an ACC_W-bit accumulator. A burst ends on in_last or when
//   MAX_LEN beats have been taken. The total, beat count and sticky overflow
//   flag are then held on the output port until downstream accepts them.
//
// Configuration macro:
//   ACC_SATURATE_EN - defined: accumulator clamps to 2^ACC_W-1 on overflow and
//                     stays clamped for the rest of the burst.
//                     undefined: accumulator wraps modulo 2^ACC_W.
//                     out_ovf is set on overflow in both builds.
//
// Parameters:
//   ACC_W    accumulator/result width (5..16)
//   MAX_LEN  maximum beats per burst (1..15)
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   input beat present
//   in_ready   stage can accept a beat
//   in_data    4-bit operand
//   in_cin     carry-in term (adds 0 or 1)
//   in_last    final beat of the burst
//   out_valid  result held and valid
//   out_ready  downstream accepts the result
//   out_sum    accumulated total
//   out_count  beats accepted in the burst
//   out_ovf    sticky overflow flag for the burst

module add_accumulator #(
  parameter int ACC_W   = 8,
  parameter int MAX_LEN = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  input  logic             in_cin,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [3:0]       out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [3:0]       MAX_CNT = 4'(MAX_LEN);
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  state_t           state, state_nxt;
  logic             live;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [3:0]       count, count_nxt;
  logic             ovf, ovf_nxt;
  logic             valid_q, valid_nxt;
  logic             beat;
  logic [4:0]       term;
  logic [ACC_W:0]   sum_ext;

  // in_ready must stay low while rst is held and only rise on the first edge
  // after release; 'live' provides that without touching the state encoding.
  assign in_ready = live && (state != HOLD);
  assign beat     = in_valid && in_ready;

  assign term    = {1'b0, in_data} + {4'b0000, in_cin};
  // One extra bit so the top bit is the carry out of the ACC_W-bit sum.
  assign sum_ext = {1'b0, acc} + (ACC_W+1)'(term);

  assign out_valid = valid_q;
  assign out_sum   = acc;
  assign out_count = count;
  assign out_ovf   = ovf;

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    count_nxt = count;
    ovf_nxt   = ovf;
    valid_nxt = valid_q;
    case (state)
      IDLE: begin
        if (beat) begin
          acc_nxt   = ACC_W'(term);
          count_nxt = 4'd1;
          ovf_nxt   = 1'b0;
          if (in_last || (MAX_CNT == 4'd1)) begin
            state_nxt = HOLD;
            valid_nxt = 1'b1;
          end else begin
            state_nxt = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (beat) begin
          count_nxt = count + 4'd1;
          ovf_nxt   = ovf | sum_ext[ACC_W];
`ifdef ACC_SATURATE_EN
          // Once clamped, hold the ceiling for the remainder of the burst.
          if (ovf || sum_ext[ACC_W]) begin
            acc_nxt = ACC_MAX;
          end else begin
            acc_nxt = sum_ext[ACC_W-1:0];
          end
`else
          acc_nxt = sum_ext[ACC_W-1:0];
`endif
          // in_last and hitting MAX_LEN together is one termination.
          if (in_last || (count_nxt == MAX_CNT)) begin
            state_nxt = HOLD;
            valid_nxt = 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      live    <= 1'b0;
      acc     <= '0;
      count   <= 4'd0;
      ovf     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      live    <= 1'b1;
      acc     <= acc_nxt;
      count   <= count_nxt;
      ovf     <= ovf_nxt;
      valid_q <= valid_nxt;
    end
  end

endmodule

// File: doc/add_accumulator.md
# add_accumulator

Sequential accumulation stage that sits directly downstream of the team's 4-bit ripple adder datapath. It consumes a stream of 4-bit operand/carry-in beats over a valid/ready handshake and sums them into a wider accumulator. At the end of a burst it presents the total, the beat count and an overflow flag on a valid/ready output port. Typical use: multi-word checksums and running totals built from 4-bit adder results.

## Interface
- ACC_W, 8, accumulator and result width; legal range 5..16.
- MAX_LEN, 15, maximum beats per burst; legal range 1..15.

- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  beat present on in_data/in_cin/in_last.
- in_ready  output  1  stage can accept a beat this cycle.
- in_data  input  4  operand to add.
- in_cin  input  1  carry-in term added with in_data (adds 0 or 1).
- in_last  input  1  marks the final beat of a burst.
- out_valid  output  1  result held and valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  ACC_W  accumulated total.
- out_count  output  4  beats accepted in this burst (1..MAX_LEN).
- out_ovf  output  1  sticky; set if any addition in the burst exceeded 2^ACC_W-1.

## Operation
- Beat transfer: in_valid && in_ready on a rising edge. Term = zero-extended in_data + in_cin, range 0..16.
- FSM states: IDLE, ACCUM, HOLD.
- IDLE: in_ready=1, out_valid=0.
  - On a beat: acc <= term, count <= 1, ovf <= 0.
  - Go to HOLD if in_last or MAX_LEN==1; otherwise go to ACCUM.
- ACCUM: in_ready=1, out_valid=0.
  - On a beat: acc <= acc+term, count <= count+1, ovf |= carry out of ACC_W bits.
  - Go to HOLD if in_last or if the new count equals MAX_LEN (forced termination).
  - Without a beat: stay in ACCUM, state unchanged.
- HOLD: in_ready=0, out_valid=1. out_sum/out_count/out_ovf stay stable until the transfer.
  - out_valid && out_ready: go to IDLE.
  - No new beat is accepted in the HOLD cycle itself.
- Arithmetic: the addition is ACC_W+1 bits wide; bit ACC_W is the overflow carry. Result handling on overflow is set by the Configuration macro.
- in_data/in_cin/in_last are ignored while in_valid=0 or in_ready=0.

## Timing
- Reset values: in_ready=0 while rst is asserted, then 1 from IDLE on the first edge after release. out_valid=0, out_sum=0, out_count=0, out_ovf=0. FSM=IDLE.
- Reset mid-burst or in HOLD: immediate clear to the values above. The partial burst is discarded and no result is emitted.
- Latency: out_valid rises in the cycle after the edge that accepts the terminating beat.
- Throughput: one beat per cycle inside a burst. Minimum one-cycle gap between bursts (the HOLD cycle); HOLD ends on the edge where out_ready=1.
- out_valid, out_sum, out_count and out_ovf are registered outputs. in_ready is decoded from the FSM state only, with no combinational path from out_ready.
- Simultaneous in_last and count reaching MAX_LEN: a single termination, count=MAX_LEN.

## Configuration
- ACC_SATURATE_EN defined: on overflow acc clamps to 2^ACC_W-1 and stays clamped for the rest of the burst; out_ovf=1.
- ACC_SATURATE_EN undefined: acc wraps modulo 2^ACC_W; out_ovf=1.

## Test plan
- Single beat in_data=0, in_cin=1, in_last=1 -> one cycle later out_valid=1, out_sum=1, out_count=1, out_ovf=0.
- Two beats (15, cin 0) then (1, cin 0, last) -> out_sum=16, out_count=2, out_ovf=0.
- ACC_W=6, five beats of (15, cin 1), last on the fifth -> out_ovf=1. out_sum=16 without ACC_SATURATE_EN; out_sum=63 with it.
- MAX_LEN=3, four beats of 2 with no in_last -> result after the third beat: out_sum=6, out_count=3. The fourth beat starts a new burst with acc=2.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD -> out_valid stays 1, outputs stable, in_ready=0. Then out_ready=1 -> IDLE next cycle.
- Assert rst after two beats (acc=7) -> all outputs zero, no out_valid. The next burst (3, last) gives out_sum=3.
